// File: rtl/cbs_pkg.sv
// Shared types and helpers for the carry-bypass subtractor.
// The block adder is common to the adder variants as well.
package cbs_pkg;

  localparam int BLK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic [4:0] blk_add4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       cin
  );
    logic [4:0] c;
    logic [3:0] s;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    return {c[4], s};
  endfunction

endpackage

// File: rtl/cbs_block4.sv
// Combinational 4-bit block: ripple sum plus bypass-muxed carry-out.
// The bypass forwards cin when every bit of the block propagates.
module cbs_block4
  import cbs_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_add;
  logic       w_p_blk;
  logic       w_c_rip;

  assign w_add   = blk_add4(i_a, i_b, i_cin);
  assign o_sum   = w_add[3:0];
  assign w_c_rip = w_add[4];
  assign w_p_blk = &(i_a ^ i_b);
  assign o_cout  = w_p_blk ? i_cin : w_c_rip;

endmodule

// File: rtl/carry_bypass_subtractor_seq.sv
// Block-serial subtractor: A + ~B + 1, one 4-bit block per clock.
// A single cbs_block4 is time-multiplexed across the operand.
module carry_bypass_subtractor_seq
  import cbs_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             OVF
);

  localparam int N     = WIDTH / BLK_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  generate
    if ((WIDTH % BLK_W) != 0 || WIDTH < BLK_W) begin : g_bad_width
      $error("WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_nb;
  logic [WIDTH-1:0] r_diff;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_bout;
  logic             r_ovf;

  logic [3:0] w_a_blk;
  logic [3:0] w_b_blk;
  logic [3:0] w_sum;
  logic       w_cout;
  logic       w_last;
  logic       w_ovf;

  assign w_a_blk = r_a[r_idx*BLK_W +: BLK_W];
  assign w_b_blk = r_nb[r_idx*BLK_W +: BLK_W];
  assign w_last  = (r_idx == LAST);

  // r_nb holds ~B, so A and B signs differ when r_a and r_nb MSBs match
  assign w_ovf = ~(r_a[WIDTH-1] ^ r_nb[WIDTH-1])
               & (w_sum[3] ^ r_a[WIDTH-1]);

  cbs_block4 u_blk (
    .i_a   (w_a_blk),
    .i_b   (w_b_blk),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_nxt = BUSY;
      BUSY: if (w_last) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    DIFF      = r_diff;
    BOUT      = r_bout;
    OVF       = r_ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_nb    <= '0;
      r_diff  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_nb    <= ~B;
            r_carry <= 1'b1;
            r_idx   <= '0;
          end
        end
        BUSY: begin
          r_diff[r_idx*BLK_W +: BLK_W] <= w_sum;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_bout <= ~w_cout;
            r_ovf  <= w_ovf;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carry_bypass_subtractor_seq.sv
// Scoreboard bench for carry_bypass_subtractor_seq at WIDTH 4/8/16/32.
module tb_carry_bypass_subtractor_seq;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        ordy = 1'b0;
  logic        iv4 = 1'b0, iv8 = 1'b0, iv16 = 1'b0, iv32 = 1'b0;
  logic        ir4, ir8, ir16, ir32;
  logic        ov4, ov8, ov16, ov32;
  logic        bo4, bo8, bo16, bo32;
  logic        of4, of8, of16, of32;
  logic [3:0]  d4;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [31:0] d32;

  int          sel_w = 16;
  logic        s_ir, s_ov, s_bo, s_of;
  logic [31:0] s_d;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  carry_bypass_subtractor_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .A(A[3:0]), .B(B[3:0]), .out_valid(ov4), .out_ready(ordy),
    .DIFF(d4), .BOUT(bo4), .OVF(of4));

  carry_bypass_subtractor_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .A(A[7:0]), .B(B[7:0]), .out_valid(ov8), .out_ready(ordy),
    .DIFF(d8), .BOUT(bo8), .OVF(of8));

  carry_bypass_subtractor_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .A(A[15:0]), .B(B[15:0]), .out_valid(ov16), .out_ready(ordy),
    .DIFF(d16), .BOUT(bo16), .OVF(of16));

  carry_bypass_subtractor_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .A(A), .B(B), .out_valid(ov32), .out_ready(ordy),
    .DIFF(d32), .BOUT(bo32), .OVF(of32));

  always_comb begin
    s_ir = 1'b0;
    s_ov = 1'b0;
    s_bo = 1'b0;
    s_of = 1'b0;
    s_d  = '0;
    case (sel_w)
      4: begin
        s_ir = ir4; s_ov = ov4; s_bo = bo4; s_of = of4; s_d = 32'(d4);
      end
      8: begin
        s_ir = ir8; s_ov = ov8; s_bo = bo8; s_of = of8; s_d = 32'(d8);
      end
      16: begin
        s_ir = ir16; s_ov = ov16; s_bo = bo16; s_of = of16; s_d = 32'(d16);
      end
      default: begin
        s_ir = ir32; s_ov = ov32; s_bo = bo32; s_of = of32; s_d = d32;
      end
    endcase
  end

  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [32:0] m;
    logic [31:0] am, bm, d;
    m    = (33'd1 << w) - 33'd1;
    am   = a & m[31:0];
    bm   = b & m[31:0];
    d    = (am - bm) & m[31:0];
    e.d  = d;
    e.bo = (am < bm);
    e.ov = (am[w-1] != bm[w-1]) && (d[w-1] != am[w-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iv(input logic v);
    iv4  = v && (sel_w == 4);
    iv8  = v && (sel_w == 8);
    iv16 = v && (sel_w == 16);
    iv32 = v && (sel_w == 32);
  endtask

  task automatic do_op(input int w, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    int   k;
    exp_t e;
    sel_w = w;
    #0;
    k = 0;
    while (!s_ir && k < 50) begin
      step();
      k++;
    end
    chk("in_ready_wait", 32'(s_ir), 32'd1);
    A = a;
    B = b;
    set_iv(1'b1);
    q.push_back(model(w, a, b));
    step();
    set_iv(1'b0);
    k = 0;
    while (!s_ov && k < 100) begin
      step();
      k++;
    end
    chk("latency", k, w / 4);
    e = q[0];
    for (int i = 0; i < stall; i++) begin
      chk("stall_ov", 32'(s_ov), 32'd1);
      chk("stall_ir", 32'(s_ir), 32'd0);
      chk("stall_diff", s_d, e.d);
      chk("stall_bout", 32'(s_bo), 32'(e.bo));
      chk("stall_ovf", 32'(s_of), 32'(e.ov));
      A = ~a;
      B = a ^ 32'h5a5a_5a5a;
      set_iv(i[0]);
      step();
    end
    set_iv(1'b0);
    chk("q_nonempty", 32'(q.size()), 32'd1);
    e = q.pop_front();
    chk("out_valid", 32'(s_ov), 32'd1);
    chk("diff", s_d, e.d);
    chk("bout", 32'(s_bo), 32'(e.bo));
    chk("ovf", 32'(s_of), 32'(e.ov));
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    chk("consumed_ov", 32'(s_ov), 32'd0);
    chk("consumed_ir", 32'(s_ir), 32'd1);
  endtask

  initial begin
    sel_w = 16;
    repeat (2) step();
    chk("rst_ir", 32'(s_ir), 32'd1);
    chk("rst_ov", 32'(s_ov), 32'd0);
    chk("rst_diff", s_d, 32'd0);
    chk("rst_bout", 32'(s_bo), 32'd0);
    chk("rst_ovf", 32'(s_of), 32'd0);
    rst_n = 1'b1;
    step();

    do_op(16, 32'h1234, 32'h0234, 0);
    do_op(16, 32'h0000, 32'h0001, 0);
    do_op(16, 32'h8000, 32'h0001, 0);
    do_op(16, 32'hFFFF, 32'hFFFF, 0);
    do_op(16, 32'h0F0F, 32'h0F0E, 0);
    do_op(16, 32'h7FFF, 32'hFFFF, 6);

    sel_w = 16;
    A = 32'h1234;
    B = 32'h0001;
    set_iv(1'b1);
    step();
    set_iv(1'b0);
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_ir", 32'(s_ir), 32'd1);
    chk("midrst_ov", 32'(s_ov), 32'd0);
    chk("midrst_diff", s_d, 32'd0);
    chk("midrst_bout", 32'(s_bo), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_out", 32'(s_ov), 32'd0);
    end
    do_op(16, 32'h0005, 32'h0003, 0);

    for (int i = 0; i < 1000; i++) do_op(4, $urandom, $urandom, 0);
    for (int i = 0; i < 1000; i++) do_op(8, $urandom, $urandom, 0);
    for (int i = 0; i < 1000; i++) do_op(32, $urandom, $urandom, 0);
    for (int i = 0; i < 200; i++) do_op(16, $urandom, $urandom, 0);
    do_op(32, 32'h8000_0000, 32'h0000_0001, 3);
    do_op(4, 32'h8, 32'h1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
